// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between the imem and dmem stages.
// Optional round-robin tie-break when MEM_ARB_RR_EN is defined; fixed dmem priority otherwise.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                imem_read_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_resp_o,
  output logic [DATA_W-1:0]   imem_rdata_o,
  input  logic                dmem_read_i,
  input  logic                dmem_write_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  input  logic [DATA_W/8-1:0] dmem_byte_en_i,
  output logic                dmem_resp_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_byte_en_o,
  input  logic                mem_resp_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic       LG_IMEM    = 1'b0;
  localparam logic       LG_DMEM    = 1'b1;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              cmd_read_r;
  logic              cmd_write_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [DATA_W-1:0] cmd_wdata_r;
  logic [BE_W-1:0]   cmd_byte_en_r;
  logic              last_grant_r;
  logic              i_req_s;
  logic              d_req_s;
  logic              grant_d_s;

  assign i_req_s = imem_read_i;
  assign d_req_s = dmem_read_i | dmem_write_i;

  // Arbitration: decide whether dmem wins the port this cycle
  always_comb begin
    grant_d_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (i_req_s && d_req_s) begin
      grant_d_s = (last_grant_r == LG_IMEM);
    end else begin
      grant_d_s = d_req_s;
    end
`else
    grant_d_s = d_req_s;
`endif
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_nxt_s = ST_SERVE_D;
        end else if (i_req_s) begin
          state_nxt_s = ST_SERVE_I;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (mem_resp_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Command registers: loaded on grant, cleared on completion so the strobes drop next cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmd_read_r    <= 1'b0;
      cmd_write_r   <= 1'b0;
      cmd_addr_r    <= {ADDR_W{1'b0}};
      cmd_wdata_r   <= {DATA_W{1'b0}};
      cmd_byte_en_r <= {BE_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      if (grant_d_s) begin
        // A simultaneous read+write is illegal; it is served as a write
        cmd_read_r    <= dmem_read_i & ~dmem_write_i;
        cmd_write_r   <= dmem_write_i;
        cmd_addr_r    <= dmem_addr_i;
        cmd_wdata_r   <= dmem_wdata_i;
        cmd_byte_en_r <= dmem_byte_en_i;
      end else if (i_req_s) begin
        cmd_read_r    <= 1'b1;
        cmd_write_r   <= 1'b0;
        cmd_addr_r    <= imem_addr_i;
        cmd_wdata_r   <= {DATA_W{1'b0}};
        cmd_byte_en_r <= {BE_W{1'b1}};
      end else begin
        cmd_read_r    <= 1'b0;
        cmd_write_r   <= 1'b0;
        cmd_addr_r    <= {ADDR_W{1'b0}};
        cmd_wdata_r   <= {DATA_W{1'b0}};
        cmd_byte_en_r <= {BE_W{1'b0}};
      end
    end else if (mem_resp_i) begin
      cmd_read_r    <= 1'b0;
      cmd_write_r   <= 1'b0;
      cmd_addr_r    <= {ADDR_W{1'b0}};
      cmd_wdata_r   <= {DATA_W{1'b0}};
      cmd_byte_en_r <= {BE_W{1'b0}};
    end
  end

  // Last-grant tracker, updated on every grant
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_r <= LG_DMEM;
    end else if ((state_r == ST_IDLE) && grant_d_s) begin
      last_grant_r <= LG_DMEM;
    end else if ((state_r == ST_IDLE) && i_req_s) begin
      last_grant_r <= LG_IMEM;
    end
  end

  assign mem_read_o    = cmd_read_r;
  assign mem_write_o   = cmd_write_r;
  assign mem_addr_o    = cmd_addr_r;
  assign mem_wdata_o   = cmd_wdata_r;
  assign mem_byte_en_o = cmd_byte_en_r;

  // Response routing: only the requester being served sees the completion
  always_comb begin
    imem_resp_o  = 1'b0;
    imem_rdata_o = {DATA_W{1'b0}};
    dmem_resp_o  = 1'b0;
    dmem_rdata_o = {DATA_W{1'b0}};
    case (state_r)
      ST_SERVE_I: begin
        if (mem_resp_i) begin
          imem_resp_o  = 1'b1;
          imem_rdata_o = mem_rdata_i;
        end else begin
          imem_resp_o  = 1'b0;
          imem_rdata_o = {DATA_W{1'b0}};
        end
      end
      ST_SERVE_D: begin
        if (mem_resp_i) begin
          dmem_resp_o  = 1'b1;
          dmem_rdata_o = mem_rdata_i;
        end else begin
          dmem_resp_o  = 1'b0;
          dmem_rdata_o = {DATA_W{1'b0}};
        end
      end
      default: begin
        imem_resp_o  = 1'b0;
        dmem_resp_o  = 1'b0;
      end
    endcase
  end

  mem_port_arbiter_chk u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dmem_read_i  (dmem_read_i),
    .dmem_write_i (dmem_write_i),
    .state_i      (state_r),
    .last_grant_i (last_grant_r),
    .mem_read_i   (cmd_read_r),
    .mem_write_i  (cmd_write_r)
  );

endmodule

// Simulation-time checks on arbiter inputs and internal consistency.
module mem_port_arbiter_chk (
  input logic       clk_i,
  input logic       rst_i,
  input logic       dmem_read_i,
  input logic       dmem_write_i,
  input logic [1:0] state_i,
  input logic       last_grant_i,
  input logic       mem_read_i,
  input logic       mem_write_i
);

  a_dmem_rw_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(dmem_read_i && dmem_write_i))
    else $error("dmem_read_i and dmem_write_i asserted together");

  a_idle_no_strobe: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_i == 2'd0) |-> !(mem_read_i || mem_write_i))
    else $error("memory strobe active while idle");

  a_last_grant_d: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_i == 2'd2) |-> (last_grant_i == 1'b1))
    else $error("last_grant disagrees with dmem service");

  a_last_grant_i: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_i == 2'd1) |-> (last_grant_i == 1'b0))
    else $error("last_grant disagrees with imem service");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_read_i;
  logic [31:0] imem_addr_i;
  logic        imem_resp_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_read_i;
  logic        dmem_write_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic [3:0]  dmem_byte_en_i;
  logic        dmem_resp_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_byte_en_o;
  logic        mem_resp_i;
  logic [31:0] mem_rdata_i;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_read_i    (imem_read_i),
    .imem_addr_i    (imem_addr_i),
    .imem_resp_o    (imem_resp_o),
    .imem_rdata_o   (imem_rdata_o),
    .dmem_read_i    (dmem_read_i),
    .dmem_write_i   (dmem_write_i),
    .dmem_addr_i    (dmem_addr_i),
    .dmem_wdata_i   (dmem_wdata_i),
    .dmem_byte_en_i (dmem_byte_en_i),
    .dmem_resp_o    (dmem_resp_o),
    .dmem_rdata_o   (dmem_rdata_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_byte_en_o  (mem_byte_en_o),
    .mem_resp_i     (mem_resp_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_quiet;
    imem_read_i    = 1'b0;
    imem_addr_i    = 32'h0;
    dmem_read_i    = 1'b0;
    dmem_write_i   = 1'b0;
    dmem_addr_i    = 32'h0;
    dmem_wdata_i   = 32'h0;
    dmem_byte_en_i = 4'h0;
    mem_resp_i     = 1'b0;
    mem_rdata_i    = 32'h0;
  endtask

  task automatic test_reset;
    logic [135:0] obs;
    logic [31:0]  exp_addr;
    logic [1:0]   exp_resp;
    exp_addr = RR_EN ? 32'h10 : 32'h20;
    exp_resp = RR_EN ? 2'b10 : 2'b01;
    rst_i = 1'b0;
    imem_read_i = 1'b1; imem_addr_i = 32'h10;
    dmem_read_i = 1'b1; dmem_addr_i = 32'h20;
    mem_resp_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    obs = {imem_resp_o, imem_rdata_o, dmem_resp_o, dmem_rdata_o, mem_read_o,
           mem_write_o, mem_addr_o, mem_wdata_o, mem_byte_en_o};
    tests_run++;
    if (obs !== 136'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, expected all zero", obs);
    end
    next_cycle;
    rst_i = 1'b1; mem_resp_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if ({mem_read_o, mem_write_o, mem_addr_o} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_release: read=%b write=%b addr=%h, expected 0/0/0", mem_read_o, mem_write_o, mem_addr_o);
    end
    next_cycle;
    @(negedge clk_i);
    tests_run++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== exp_addr) begin
      tests_failed++;
      $display("FAIL first_grant: read=%b addr=%h, expected read=1 addr=%h", mem_read_o, mem_addr_o, exp_addr);
    end
    next_cycle;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h11;
    @(negedge clk_i);
    tests_run++;
    if ({imem_resp_o, dmem_resp_o} !== exp_resp) begin
      tests_failed++;
      $display("FAIL first_resp: {i,d}resp=%b, expected %b", {imem_resp_o, dmem_resp_o}, exp_resp);
    end
    next_cycle;
    drive_quiet;
    @(negedge clk_i);
    tests_run++;
    if (mem_read_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_drop: read=%b, expected 0", mem_read_o);
    end
  endtask

  task automatic test_lone_imem;
    next_cycle;
    imem_read_i = 1'b1; imem_addr_i = 32'h60;
    next_cycle;
    @(negedge clk_i);
    tests_run++;
    if ({mem_read_o, mem_write_o, mem_addr_o, mem_byte_en_o} !== {1'b1, 1'b0, 32'h60, 4'hF}) begin
      tests_failed++;
      $display("FAIL imem_strobe: read=%b write=%b addr=%h be=%h, expected 1/0/00000060/f",
               mem_read_o, mem_write_o, mem_addr_o, mem_byte_en_o);
    end
    repeat (2) next_cycle;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h00000013;
    @(negedge clk_i);
    tests_run++;
    if ({imem_resp_o, imem_rdata_o, dmem_resp_o, dmem_rdata_o} !== {1'b1, 32'h13, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL imem_resp: iresp=%b irdata=%h dresp=%b drdata=%h, expected 1/00000013/0/0",
               imem_resp_o, imem_rdata_o, dmem_resp_o, dmem_rdata_o);
    end
    next_cycle;
    drive_quiet;
    @(negedge clk_i);
    tests_run++;
    if (mem_read_o !== 1'b0 || imem_resp_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL imem_drop: read=%b iresp=%b, expected 0/0", mem_read_o, imem_resp_o);
    end
  endtask

  task automatic test_dmem_write;
    next_cycle;
    dmem_write_i = 1'b1; dmem_addr_i = 32'h100; dmem_wdata_i = 32'hDEADBEEF; dmem_byte_en_i = 4'b0011;
    next_cycle;
    @(negedge clk_i);
    tests_run++;
    if ({mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_byte_en_o} !==
        {1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011}) begin
      tests_failed++;
      $display("FAIL dmem_write_cmd: read=%b write=%b addr=%h wdata=%h be=%b, expected 0/1/00000100/deadbeef/0011",
               mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_byte_en_o);
    end
    next_cycle;
    dmem_addr_i = 32'h200;
    @(negedge clk_i);
    tests_run++;
    if (mem_addr_o !== 32'h100 || mem_write_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL dmem_addr_hold: addr=%h write=%b, expected 00000100/1", mem_addr_o, mem_write_o);
    end
    next_cycle;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h55;
    @(negedge clk_i);
    tests_run++;
    if ({dmem_resp_o, dmem_rdata_o, imem_resp_o, mem_addr_o} !== {1'b1, 32'h55, 1'b0, 32'h100}) begin
      tests_failed++;
      $display("FAIL dmem_resp: dresp=%b drdata=%h iresp=%b addr=%h, expected 1/00000055/0/00000100",
               dmem_resp_o, dmem_rdata_o, imem_resp_o, mem_addr_o);
    end
    next_cycle;
    drive_quiet;
    @(negedge clk_i);
    tests_run++;
    if (mem_write_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL dmem_drop: write=%b, expected 0", mem_write_o);
    end
  endtask

  task automatic test_simultaneous;
    logic        exp_d [3];
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    exp_d[0] = ~RR_EN;
    exp_d[1] = 1'b1;
    exp_d[2] = 1'b0;
    next_cycle;
    imem_read_i = 1'b1; imem_addr_i = 32'h64;
    dmem_read_i = 1'b1; dmem_addr_i = 32'h80;
    for (int k = 0; k < 3; k++) begin
      exp_addr = exp_d[k] ? 32'h80 : 32'h64;
      rdata = 32'h10000000 + 32'(k);
      @(negedge clk_i);
      tests_run++;
      if (mem_read_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL tie_idle_%0d: read=%b, expected 0", k, mem_read_o);
      end
      next_cycle;
      @(negedge clk_i);
      tests_run++;
      if (mem_read_o !== 1'b1 || mem_addr_o !== exp_addr) begin
        tests_failed++;
        $display("FAIL tie_grant_%0d: read=%b addr=%h, expected 1/%h", k, mem_read_o, mem_addr_o, exp_addr);
      end
      next_cycle;
      mem_resp_i = 1'b1; mem_rdata_i = rdata;
      @(negedge clk_i);
      tests_run++;
      if ({dmem_resp_o, dmem_rdata_o, imem_resp_o, imem_rdata_o} !==
          (exp_d[k] ? {1'b1, rdata, 1'b0, 32'h0} : {1'b0, 32'h0, 1'b1, rdata})) begin
        tests_failed++;
        $display("FAIL tie_resp_%0d: dresp=%b drdata=%h iresp=%b irdata=%h, expected %s side with %h",
                 k, dmem_resp_o, dmem_rdata_o, imem_resp_o, imem_rdata_o, exp_d[k] ? "dmem" : "imem", rdata);
      end
      next_cycle;
      mem_resp_i = 1'b0;
      if (k == 1) dmem_read_i = 1'b0;
      if (k == 2) imem_read_i = 1'b0;
    end
    @(negedge clk_i);
    tests_run++;
    if (mem_read_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_done: read=%b, expected 0", mem_read_o);
    end
    drive_quiet;
  endtask

  task automatic test_spurious_idle;
    next_cycle;
    mem_resp_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    tests_run++;
    if ({imem_resp_o, dmem_resp_o, imem_rdata_o, dmem_rdata_o, mem_read_o, mem_write_o} !== 68'd0) begin
      tests_failed++;
      $display("FAIL spurious_resp: iresp=%b dresp=%b irdata=%h drdata=%h, expected all zero",
               imem_resp_o, dmem_resp_o, imem_rdata_o, dmem_rdata_o);
    end
    next_cycle;
    mem_resp_i = 1'b0;
    imem_read_i = 1'b1; imem_addr_i = 32'h44;
    next_cycle;
    @(negedge clk_i);
    tests_run++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h44) begin
      tests_failed++;
      $display("FAIL spurious_still_idle: read=%b addr=%h, expected 1/00000044", mem_read_o, mem_addr_o);
    end
    next_cycle;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h9;
    next_cycle;
    drive_quiet;
  endtask

  task automatic test_reset_mid;
    next_cycle;
    dmem_write_i = 1'b1; dmem_addr_i = 32'h300; dmem_wdata_i = 32'h12345678; dmem_byte_en_i = 4'hF;
    next_cycle;
    @(negedge clk_i);
    tests_run++;
    if (mem_write_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_write: write=%b, expected 1", mem_write_o);
    end
    #1;
    rst_i = 1'b0;
    dmem_write_i = 1'b0;
    #1;
    tests_run++;
    if ({mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o} !== 66'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: write=%b read=%b addr=%h wdata=%h, expected all zero",
               mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o);
    end
    repeat (2) next_cycle;
    rst_i = 1'b1;
    next_cycle;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h77;
    @(negedge clk_i);
    tests_run++;
    if ({dmem_resp_o, dmem_rdata_o, imem_resp_o, mem_write_o} !== 35'd0) begin
      tests_failed++;
      $display("FAIL late_resp: dresp=%b drdata=%h iresp=%b write=%b, expected all zero",
               dmem_resp_o, dmem_rdata_o, imem_resp_o, mem_write_o);
    end
    next_cycle;
    drive_quiet;
  endtask

  initial begin
    rst_i = 1'b0;
    drive_quiet;
    test_reset;
    test_lone_imem;
    test_dmem_write;
    test_simultaneous;
    test_spurious_idle;
    test_reset_mid;
    repeat (2) next_cycle;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
